// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared rv32i encodings for the writeback stage
package rv32i_pkg;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_ALU  = 2'd1;
  localparam logic [1:0] KIND_LOAD = 2'd2;
  localparam logic [1:0] KIND_LINK = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef logic [0:0] wb_state_t;
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_MEM = 1'b1;

  function automatic logic load_illegal(input logic [2:0] funct3);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    return (((funct3 == F3_LH) || (funct3 == F3_LHU)) && addr_lo[0]) ||
           ((funct3 == F3_LW) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - retire handshake, load data and regfile write bundle
interface wb_stage_if #(parameter int XLEN = 32);
  import rv32i_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_kind;
  logic [4:0]      in_rd;
  logic [2:0]      in_funct3;
  logic [1:0]      in_addr_lo;
  logic [XLEN-1:0] in_result;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            w_enable;
  logic [4:0]      w_reg_name;
  logic [XLEN-1:0] w_reg_val;
  logic            load_err;
  logic [XLEN-1:0] retire_cnt;

  modport master (
    output in_valid, in_kind, in_rd, in_funct3, in_addr_lo, in_result, mem_rvalid, mem_rdata,
    input  in_ready, w_enable, w_reg_name, w_reg_val, load_err, retire_cnt
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_funct3, in_addr_lo, in_result, mem_rvalid, mem_rdata,
    output in_ready, w_enable, w_reg_name, w_reg_val, load_err, retire_cnt
  );

endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - shift the loaded word to its byte lane and extend by funct3
module load_align
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] value_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    unique case (funct3_i)
      F3_LB:   value_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LBU:  value_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LH:   value_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LHU:  value_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: value_o = shifted;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - rv32i writeback: retire handshake, load wait/align, regfile write
module wb_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  wb_stage_if.slave   bus
);

  logic [0:0]      state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lo_q, lo_d;
  logic            w_en_q, w_en_d;
  logic [4:0]      w_name_q, w_name_d;
  logic [XLEN-1:0] w_val_q, w_val_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] retire_q, retire_d;
  logic [XLEN-1:0] load_val;
  logic            accept;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3_i  (f3_q),
    .addr_lo_i (lo_q),
    .rdata_i   (bus.mem_rdata),
    .value_o   (load_val)
  );

  assign accept = bus.in_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    f3_d     = f3_q;
    lo_d     = lo_q;
    w_en_d   = 1'b0;
    w_name_d = w_name_q;
    w_val_d  = w_val_q;
    err_d    = 1'b0;
    retire_d = retire_q;
    if (state_q == ST_IDLE) begin
      if (accept) begin
        if (bus.in_kind == KIND_LOAD) begin
          if (load_illegal(bus.in_funct3) || load_misaligned(bus.in_funct3, bus.in_addr_lo)) begin
            err_d = 1'b1;
          end else begin
            rd_d    = bus.in_rd;
            f3_d    = bus.in_funct3;
            lo_d    = bus.in_addr_lo;
            state_d = ST_WAIT_MEM;
          end
        end else begin
          // NONE still retires; name/value only move when a real write happens
          retire_d = retire_q + XLEN'(1);
          if ((bus.in_rd != 5'd0) && (bus.in_kind != KIND_NONE)) begin
            w_en_d   = 1'b1;
            w_name_d = bus.in_rd;
            w_val_d  = bus.in_result;
          end
        end
      end
    end else if (bus.mem_rvalid) begin
      retire_d = retire_q + XLEN'(1);
      state_d  = ST_IDLE;
      if (rd_q != 5'd0) begin
        w_en_d   = 1'b1;
        w_name_d = rd_q;
        w_val_d  = load_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rd_q     <= '0;
      f3_q     <= '0;
      lo_q     <= '0;
      w_en_q   <= 1'b0;
      w_name_q <= '0;
      w_val_q  <= '0;
      err_q    <= 1'b0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      f3_q     <= f3_d;
      lo_q     <= lo_d;
      w_en_q   <= w_en_d;
      w_name_q <= w_name_d;
      w_val_q  <= w_val_d;
      err_q    <= err_d;
      retire_q <= retire_d;
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.w_enable   = w_en_q;
  assign bus.w_reg_name = w_name_q;
  assign bus.w_reg_val  = w_val_q;
  assign bus.load_err   = err_q;
  assign bus.retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed vector bench for wb_stage
module tb_wb_stage;
  import rv32i_pkg::*;

  typedef struct {
    logic        v;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] res;
    logic        rv;
    logic [31:0] rdata;
    logic        wen;
    logic [4:0]  wname;
    logic [31:0] wval;
    logic        err;
    logic        rdy;
    logic [31:0] ret;
  } vec_t;

  localparam logic [31:0] RDATA = 32'h80FF1234;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_miss = 0;
  logic [31:0] rf [32] = '{default: 32'h0};
  logic [31:0] exp_ret;
  vec_t tbl [16];

  wb_stage_if #(.XLEN(32)) bus ();

  wb_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference regfile: x0 never written
  always @(posedge clk) begin
    if (bus.w_enable && (bus.w_reg_name != 5'd0)) rf[bus.w_reg_name] <= bus.w_reg_val;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] kind, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] res,
                       input logic rv, input logic [31:0] rdata);
    bus.in_valid   = v;
    bus.in_kind    = kind;
    bus.in_rd      = rd;
    bus.in_funct3  = f3;
    bus.in_addr_lo = lo;
    bus.in_result  = res;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] kind, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] res,
                              input logic rv, input logic wen, input logic [4:0] wname,
                              input logic [31:0] wval, input logic err, input logic rdy,
                              input logic [31:0] ret);
    vec_t t;
    t = '{v, kind, rd, f3, lo, res, rv, RDATA, wen, wname, wval, err, rdy, ret};
    return t;
  endfunction

  initial begin
    tbl[0]  = mk(1, KIND_ALU,  5'd5,  3'd0,  2'd0, 32'h2A,   0, 1, 5'd5,  32'h2A,       0, 1, 1);
    tbl[1]  = mk(1, KIND_LINK, 5'd3,  3'd0,  2'd0, 32'h35,   0, 1, 5'd3,  32'h35,       0, 1, 2);
    tbl[2]  = mk(1, KIND_ALU,  5'd0,  3'd0,  2'd0, 32'hDEAD, 0, 0, 5'd3,  32'h35,       0, 1, 3);
    tbl[3]  = mk(1, KIND_NONE, 5'd9,  3'd0,  2'd0, 32'h99,   0, 0, 5'd3,  32'h35,       0, 1, 4);
    tbl[4]  = mk(0, KIND_ALU,  5'd6,  3'd0,  2'd0, 32'h66,   0, 0, 5'd3,  32'h35,       0, 1, 4);
    tbl[5]  = mk(1, KIND_LOAD, 5'd4,  F3_LW, 2'd2, 32'h0,    0, 0, 5'd3,  32'h35,       1, 1, 4);
    tbl[6]  = mk(0, KIND_ALU,  5'd0,  3'd0,  2'd0, 32'h0,    0, 0, 5'd3,  32'h35,       0, 1, 4);
    tbl[7]  = mk(1, KIND_LOAD, 5'd4,  3'b011,2'd0, 32'h0,    0, 0, 5'd3,  32'h35,       1, 1, 4);
    tbl[8]  = mk(1, KIND_LOAD, 5'd4,  F3_LH, 2'd1, 32'h0,    0, 0, 5'd3,  32'h35,       1, 1, 4);
    tbl[9]  = mk(0, KIND_ALU,  5'd0,  3'd0,  2'd0, 32'h0,    1, 0, 5'd3,  32'h35,       0, 1, 4);
    tbl[10] = mk(1, KIND_LOAD, 5'd10, F3_LB, 2'd3, 32'h0,    0, 0, 5'd3,  32'h35,       0, 0, 4);
    tbl[11] = mk(1, KIND_ALU,  5'd11, 3'd0,  2'd0, 32'h77,   1, 1, 5'd10, 32'hFFFFFF80, 0, 1, 5);
    tbl[12] = mk(0, KIND_ALU,  5'd0,  3'd0,  2'd0, 32'h0,    0, 0, 5'd10, 32'hFFFFFF80, 0, 1, 5);
    tbl[13] = mk(1, KIND_LOAD, 5'd0,  F3_LW, 2'd0, 32'h0,    1, 0, 5'd10, 32'hFFFFFF80, 0, 0, 5);
    tbl[14] = mk(0, KIND_ALU,  5'd0,  3'd0,  2'd0, 32'h0,    1, 0, 5'd10, 32'hFFFFFF80, 0, 1, 6);
    tbl[15] = mk(1, KIND_LOAD, 5'd0,  3'b111,2'd0, 32'h0,    0, 0, 5'd10, 32'hFFFFFF80, 1, 1, 6);

    drive(1, KIND_ALU, 5'd5, 3'd0, 2'd0, 32'h1234, 1, RDATA);
    rst = 1'b1;
    step();
    step();
    chk("rst_w_enable", 32'(bus.w_enable), 32'd0);
    chk("rst_w_reg_name", 32'(bus.w_reg_name), 32'd0);
    chk("rst_w_reg_val", bus.w_reg_val, 32'd0);
    chk("rst_load_err", 32'(bus.load_err), 32'd0);
    chk("rst_retire_cnt", bus.retire_cnt, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    drive(0, KIND_NONE, 5'd0, 3'd0, 2'd0, 32'h0, 0, RDATA);
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].kind, tbl[i].rd, tbl[i].f3, tbl[i].lo, tbl[i].res, tbl[i].rv, tbl[i].rdata);
      step();
      chk($sformatf("v%0d_w_enable", i), 32'(bus.w_enable), 32'(tbl[i].wen));
      chk($sformatf("v%0d_w_reg_name", i), 32'(bus.w_reg_name), 32'(tbl[i].wname));
      chk($sformatf("v%0d_w_reg_val", i), bus.w_reg_val, tbl[i].wval);
      chk($sformatf("v%0d_load_err", i), 32'(bus.load_err), 32'(tbl[i].err));
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_retire_cnt", i), bus.retire_cnt, tbl[i].ret);
    end
    drive(0, KIND_NONE, 5'd0, 3'd0, 2'd0, 32'h0, 0, RDATA);
    step();
    chk("rf_x5", rf[5], 32'h2A);
    chk("rf_x3", rf[3], 32'h35);
    chk("rf_x0", rf[0], 32'h0);
    chk("rf_x10", rf[10], 32'hFFFFFF80);
    chk("rf_x11_untouched", rf[11], 32'h0);

    // each load waits three cycles for rvalid
    exp_ret = 32'd6;
    begin
      logic [2:0]  lf3 [5];
      logic [1:0]  llo [5];
      logic [31:0] lexp [5];
      lf3 = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW};
      llo = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0};
      lexp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF1234};
      for (int i = 0; i < 5; i++) begin
        drive(1, KIND_LOAD, 5'(12 + i), lf3[i], llo[i], 32'h0, 0, RDATA);
        step();
        drive(0, KIND_NONE, 5'd0, 3'd0, 2'd0, 32'h0, 0, RDATA);
        for (int c = 0; c < 3; c++) begin
          chk($sformatf("ld%0d_ready_low%0d", i, c), 32'(bus.in_ready), 32'd0);
          chk($sformatf("ld%0d_wen_low%0d", i, c), 32'(bus.w_enable), 32'd0);
          if (c == 2) bus.mem_rvalid = 1'b1;
          step();
        end
        bus.mem_rvalid = 1'b0;
        exp_ret = exp_ret + 32'd1;
        chk($sformatf("ld%0d_w_enable", i), 32'(bus.w_enable), 32'd1);
        chk($sformatf("ld%0d_w_reg_name", i), 32'(bus.w_reg_name), 32'(12 + i));
        chk($sformatf("ld%0d_w_reg_val", i), bus.w_reg_val, lexp[i]);
        chk($sformatf("ld%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
        chk($sformatf("ld%0d_retire_cnt", i), bus.retire_cnt, exp_ret);
        step();
        chk($sformatf("ld%0d_wen_pulse", i), 32'(bus.w_enable), 32'd0);
        chk($sformatf("ld%0d_rf", i), rf[12 + i], lexp[i]);
      end
    end

    // reset while a load is outstanding drops it
    drive(1, KIND_LOAD, 5'd7, F3_LW, 2'd0, 32'h0, 0, RDATA);
    step();
    drive(0, KIND_NONE, 5'd0, 3'd0, 2'd0, 32'h0, 0, RDATA);
    chk("rstw_ready_low", 32'(bus.in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstw_ready_async", 32'(bus.in_ready), 32'd1);
    chk("rstw_retire_async", bus.retire_cnt, 32'd0);
    step();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    step();
    bus.mem_rvalid = 1'b0;
    chk("rstw_w_enable", 32'(bus.w_enable), 32'd0);
    chk("rstw_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rstw_retire_cnt", bus.retire_cnt, 32'd0);
    step();
    chk("rstw_rf_x7", rf[7], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the rv32i core, directly upstream of the register file write port. Accepts retiring instructions from execute/memory over a valid/ready handshake, waits for load data when needed, aligns and sign/zero-extends loads, and drives the regfile's `w_enable` / `w_reg_name` / `w_reg_val` from registers. It suppresses writes to x0 and keeps a retired-instruction counter.

## Interface

Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream instruction available.
- `in_ready`  out  1  stage can accept; combinational, equals (state == IDLE).
- `in_kind`  in  2  0 NONE, 1 ALU, 2 LOAD, 3 LINK.
- `in_rd`  in  5  destination register name.
- `in_funct3`  in  3  load width/sign; used only for LOAD.
- `in_addr_lo`  in  2  load byte address [1:0].
- `in_result`  in  32  ALU result (ALU) or PC+4 (LINK).
- `mem_rvalid`  in  1  load data valid, single-cycle pulse.
- `mem_rdata`  in  32  raw aligned word from data memory.
- `w_enable`  out  1  to regfile; registered.
- `w_reg_name`  out  5  to regfile; registered.
- `w_reg_val`  out  32  to regfile; registered.
- `load_err`  out  1  one-cycle pulse on misaligned or illegal load.
- `retire_cnt`  out  32  retired instruction count; wraps modulo 2^32.

## Operation

- FSM has two states, IDLE and WAIT_MEM. Reset state is IDLE.
- Accept occurs when `in_valid && in_ready` is sampled at an edge.
- IDLE, accept of NONE, ALU or LINK: stay in IDLE.
  - Register `w_enable = (in_rd != 0) && kind != NONE`, `w_reg_name = in_rd`, `w_reg_val = in_result`.
  - Increment `retire_cnt`.
- IDLE, accept of LOAD, legal and aligned: latch rd, funct3 and addr_lo, then go to WAIT_MEM.
- IDLE, accept of LOAD, misaligned or illegal: no write, no retire, `load_err` = 1 for the next cycle, stay in IDLE.
  - Misaligned: LH/LHU with addr_lo[0] = 1, or LW with addr_lo != 0.
  - Illegal: funct3 ∈ {011, 110, 111}.
- WAIT_MEM, `mem_rvalid` = 1: write the aligned value to the latched rd, apply the x0 suppression rule, increment `retire_cnt`, return to IDLE.
- WAIT_MEM, `mem_rvalid` = 0: hold.
- `mem_rvalid` in IDLE is ignored.
- Load alignment:
  - `byte = mem_rdata >> (8*addr_lo)`.
  - LB (000) sign-extends bits [7:0]; LBU (100) zero-extends [7:0].
  - LH (001) sign-extends [15:0]; LHU (101) zero-extends [15:0].
  - LW (010) passes the word through.
- `w_reg_name` and `w_reg_val` hold their last value when `w_enable` is 0.
- `retire_cnt` increments by exactly 1 per retire, never by 2.
- Reset mid-WAIT_MEM: the pending load is dropped. A `mem_rvalid` arriving after reset deassertion is ignored, because the state is IDLE.

## Timing

- Reset values: `w_enable` 0, `w_reg_name` 0, `w_reg_val` 0, `load_err` 0, `retire_cnt` 0, `in_ready` 1.
- Non-load latency: accept at edge N → `w_*` valid during cycle N..N+1 → regfile commits at edge N+1.
- Throughput: one non-load per cycle; back-to-back accepts give back-to-back `w_enable`.
- Load: `in_ready` falls after the accept edge and rises after the edge that samples `mem_rvalid`.
  - `w_enable` is high for the cycle after that edge.
  - Minimum load occupancy is 2 cycles: accept, plus rvalid in the next cycle.
- `w_enable` and `load_err` are each high for exactly one cycle per event.

## Structure

- Shared package `rv32i_pkg` holds:
  - kind encodings (KIND_NONE, KIND_ALU, KIND_LOAD, KIND_LINK);
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - the FSM state type.
- Sub-module `load_align`: combinational; inputs funct3, addr_lo, rdata; outputs the extended value. The `illegal` flag is computed in the package as a function.

## Test plan

- Reset: assert `rst` with `in_valid` = 1 → all outputs at reset values, `in_ready` = 1, `retire_cnt` = 0.
- ALU accept rd=5, result=0x2A, then LINK rd=3, result=0x35 on the next cycle:
  - `w_enable` high for two consecutive cycles (5/0x2A, then 3/0x35).
  - Regfile reads x5 = 0x2A and x3 = 0x35.
  - `retire_cnt` = 2.
- ALU rd=0, result=0xDEAD → `w_enable` stays 0, `retire_cnt` increments, regfile x0 reads 0.
- `mem_rdata` = 0x80FF1234, `mem_rvalid` after a 3-cycle wait, `in_ready` low for 3 cycles. Expected `w_reg_val` per load:
  - LB addr_lo=3 → 0xFFFFFF80.
  - LBU addr_lo=3 → 0x00000080.
  - LH addr_lo=2 → 0xFFFF80FF.
  - LHU addr_lo=2 → 0x000080FF.
  - LW addr_lo=0 → 0x80FF1234.
- LW addr_lo=2, and funct3=011 → `load_err` one-cycle pulse each, no write, `retire_cnt` unchanged, `in_ready` stays 1.
- LOAD rd=7 accepted, `rst` pulsed in WAIT_MEM, then `mem_rvalid` = 1 → no write to x7, `in_ready` = 1, `retire_cnt` = 0.
